mem_arbiter: RTL

- Shares the single memory port between two masters: CPU (port 0) and DMA/display engine (port 1).
- Each master has a req/ack handshake. The arbiter picks one round-robin, drives the memory strobes/address/data for one transaction, waits a fixed memory latency, then returns read data with a one-cycle ack.
- Sits between the masters and the memory's tristate BUS adapter. The arbiter side uses separate rdata/wdata and never drives the inout.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_rr_pick.sv | 21 ++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter.
// Op codes, FSM encoding and port indices.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MW_NONE = 2'd0,
    MW_WORD = 2'd1,
    MW_DMA  = 2'd2,
    MW_BYTE = 2'd3
  } mw_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DMA = 1'b1;

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way round-robin pick: req + last owner -> one-hot winner.
// Shared with the IO-bus arbiter.
import mem_arbiter_pkg::*;

module mem_rr_pick (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    unique case (1'b1)
      (req == 2'b11): win = (last_gnt == P_DMA) ? 2'b01 : 2'b10;
      (req == 2'b01): win = 2'b01;
      (req == 2'b10): win = 2'b10;
      default:        win = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for the single memory port.
// One transaction at a time, fixed read latency, one-cycle ack.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic [1:0]    c_op,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic [1:0]    d_op,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_rd,
  output logic [1:0]    mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    gnt
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    op_q, op_n;
  logic          last_gnt, last_n;
  logic [1:0]    win, gnt_n;
  logic          done;
  logic          busy_n;
  logic          mem_rd_n;
  logic [1:0]    mem_wr_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_wdata_n;
  logic          c_ack_n, d_ack_n;
  logic [DW-1:0] c_rdata_n, d_rdata_n;
  logic [1:0]    sel_op;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  mem_rr_pick u_pick (
    .req      ({d_req, c_req}),
    .last_gnt (last_gnt),
    .win      (win)
  );

  assign sel_op    = win[P_DMA] ? d_op    : c_op;
  assign sel_addr  = win[P_DMA] ? d_addr  : c_addr;
  assign sel_wdata = win[P_DMA] ? d_wdata : c_wdata;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    op_n        = op_q;
    gnt_n       = gnt;
    last_n      = last_gnt;
    done        = 1'b0;
    mem_rd_n    = 1'b0;
    mem_wr_n    = 2'b00;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    c_ack_n     = 1'b0;
    d_ack_n     = 1'b0;
    c_rdata_n   = c_rdata;
    d_rdata_n   = d_rdata;
    unique case (state)
      IDLE: begin
        if (|win) begin
          state_n     = ISSUE;
          op_n        = sel_op;
          gnt_n       = win;
          last_n      = win[P_DMA];
          mem_rd_n    = (sel_op == MW_NONE);
          mem_wr_n    = sel_op;
          mem_addr_n  = sel_addr;
          mem_wdata_n = (sel_op == MW_NONE) ? '0 : sel_wdata;
        end
      end
      ISSUE: begin
        if (op_q == MW_NONE && MEM_LAT > 1) begin
          state_n = WAIT;
          cnt_n   = CW'(MEM_LAT - 1);
        end else begin
          done = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == CW'(1)) done = 1'b1;
        else cnt_n = cnt - CW'(1);
      end
      RESP: begin
        state_n = IDLE;
        gnt_n   = 2'b00;
      end
    endcase
    // Read data is sampled on the same edge that enters RESP.
    if (done) begin
      state_n = RESP;
      c_ack_n = gnt[P_CPU];
      d_ack_n = gnt[P_DMA];
      if (op_q == MW_NONE) begin
        if (gnt[P_CPU]) c_rdata_n = mem_rdata;
        if (gnt[P_DMA]) d_rdata_n = mem_rdata;
      end
    end
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= 2'b00;
      gnt       <= 2'b00;
      last_gnt  <= P_DMA;
      busy      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      c_ack     <= 1'b0;
      d_ack     <= 1'b0;
      c_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      op_q      <= op_n;
      gnt       <= gnt_n;
      last_gnt  <= last_n;
      busy      <= busy_n;
      mem_rd    <= mem_rd_n;
      mem_wr    <= mem_wr_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      c_ack     <= c_ack_n;
      d_ack     <= d_ack_n;
      c_rdata   <= c_rdata_n;
      d_rdata   <= d_rdata_n;
    end
  end

endmodule
